// File: rtl/calc_executor.sv
// Multi-cycle integer calculator: single-cycle ADD/SUB and 16-step MUL/DIV that
// share one 32-bit working register. Result and error are held until the next completion.
module calc_executor #(
  parameter int              IC_N   = 5,
  parameter logic [IC_N-1:0] OP_ADD = IC_N'(1),
  parameter logic [IC_N-1:0] OP_SUB = IC_N'(2),
  parameter logic [IC_N-1:0] OP_MUL = IC_N'(3),
  parameter logic [IC_N-1:0] OP_DIV = IC_N'(4)
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [15:0]     SRC,
  input  logic [15:0]     DST,
  input  logic [IC_N-1:0] ALU_OP,
  input  logic            finish,
  output logic [15:0]     result,
  output logic            valid,
  output logic            busy,
  output logic            err
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [15:0]       result_nxt;
  logic              err_nxt, valid_nxt, busy_nxt;
  logic [15:0]       a_q, b_q, a_nxt, b_nxt;
  logic [IC_N-1:0]   op_q, op_nxt;
  logic [31:0]       work, work_nxt;
  logic [31:0]       mul_w, div_w;
  logic [16:0]       add17, sub17;

  // Shift-add step: work = {partial product high, remaining multiplier bits}.
  function automatic logic [31:0] mul_step(input logic [31:0] w, input logic [15:0] m);
    logic [16:0] acc;
    acc = w[0] ? ({1'b0, w[31:16]} + {1'b0, m}) : {1'b0, w[31:16]};
    return {acc, w[15:1]};
  endfunction

  // Restoring step: work = {partial remainder, dividend bits / quotient bits}.
  function automatic logic [31:0] div_step(input logic [31:0] w, input logic [15:0] d);
    logic [16:0] rem;
    logic [16:0] diff;
    rem  = {w[31:16], w[15]};
    diff = rem - {1'b0, d};
    if (rem >= {1'b0, d}) return {diff[15:0], w[14:0], 1'b1};
    return {rem[15:0], w[14:0], 1'b0};
  endfunction

  assign mul_w = mul_step(work, a_q);
  assign div_w = div_step(work, b_q);
  assign add17 = {1'b0, a_q} + {1'b0, b_q};
  assign sub17 = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    result_nxt = result;
    err_nxt    = err;
    valid_nxt  = 1'b0;
    busy_nxt   = busy;
    a_nxt      = a_q;
    b_nxt      = b_q;
    op_nxt     = op_q;
    work_nxt   = work;
    case (state)
      IDLE: begin
        if (finish) begin
          a_nxt     = DST;
          b_nxt     = SRC;
          op_nxt    = ALU_OP;
          cnt_nxt   = 4'd0;
          busy_nxt  = 1'b1;
          state_nxt = EXEC;
          work_nxt  = (ALU_OP == OP_MUL) ? {16'h0000, SRC} : {16'h0000, DST};
        end
      end
      default: begin
        // Completion writes result/err, pulses valid and drops busy together.
        if (op_q == OP_ADD) begin
          result_nxt = add17[15:0];
          err_nxt    = add17[16];
          valid_nxt  = 1'b1;
        end else if (op_q == OP_SUB) begin
          result_nxt = sub17[15:0];
          err_nxt    = sub17[16];
          valid_nxt  = 1'b1;
        end else if (op_q == OP_MUL) begin
          work_nxt = mul_w;
          cnt_nxt  = cnt + 4'd1;
          if (cnt == 4'd15) begin
            result_nxt = mul_w[15:0];
            err_nxt    = |mul_w[31:16];
            valid_nxt  = 1'b1;
          end
        end else if (op_q == OP_DIV) begin
          if (b_q == 16'h0000) begin
            result_nxt = 16'hFFFF;
            err_nxt    = 1'b1;
            valid_nxt  = 1'b1;
          end else begin
            work_nxt = div_w;
            cnt_nxt  = cnt + 4'd1;
            if (cnt == 4'd15) begin
              result_nxt = div_w[15:0];
              err_nxt    = 1'b0;
              valid_nxt  = 1'b1;
            end
          end
        end else begin
          result_nxt = 16'h0000;
          err_nxt    = 1'b1;
          valid_nxt  = 1'b1;
        end
        if (valid_nxt) begin
          busy_nxt  = 1'b0;
          cnt_nxt   = 4'd0;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // Control state and visible outputs
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      result <= 16'h0000;
      err    <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      result <= result_nxt;
      err    <= err_nxt;
      valid  <= valid_nxt;
      busy   <= busy_nxt;
    end
  end

  // Operand and working datapath
  always_ff @(posedge Clock) begin
    a_q  <= a_nxt;
    b_q  <= b_nxt;
    op_q <= op_nxt;
    work <= work_nxt;
  end

endmodule

// File: tb/tb_calc_executor.sv
// Randomized self-checking bench for calc_executor against a plain-arithmetic model.
module tb_calc_executor;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] SRC = '0, DST = '0;
  logic [4:0]  ALU_OP = '0;
  logic        finish = 1'b0;
  logic [15:0] result;
  logic        valid, busy, err;

  int checks = 0;
  int failures = 0;

  calc_executor dut (
    .Clock(Clock), .Reset(Reset), .SRC(SRC), .DST(DST), .ALU_OP(ALU_OP),
    .finish(finish), .result(result), .valid(valid), .busy(busy), .err(err)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: expected result, error and edges from capture to valid.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [4:0] op,
                       output logic [15:0] res, output logic e, output int lat);
    logic [31:0] full;
    case (op)
      5'd1: begin full = 32'(a) + 32'(b); res = full[15:0]; e = full > 32'hFFFF; lat = 1; end
      5'd2: begin res = a - b; e = a < b; lat = 1; end
      5'd3: begin full = 32'(a) * 32'(b); res = full[15:0]; e = full > 32'hFFFF; lat = 16; end
      5'd4: begin
        if (b == 0) begin res = 16'hFFFF; e = 1'b1; lat = 1; end
        else begin res = a / b; e = 1'b0; lat = 16; end
      end
      default: begin res = 16'h0000; e = 1'b1; lat = 1; end
    endcase
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 40) begin
      @(posedge Clock); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] op);
    logic [15:0] er;
    logic        ee;
    int          lat, n;
    model(a, b, op, er, ee, lat);
    @(negedge Clock);
    DST = a; SRC = b; ALU_OP = op; finish = 1'b1;
    @(posedge Clock); #1;
    finish = 1'b0;
    check({tag, "_busy_start"}, busy, 1);
    wait_valid(n);
    check({tag, "_latency"}, n, lat);
    check({tag, "_result"}, result, er);
    check({tag, "_err"}, err, ee);
    check({tag, "_busy_done"}, busy, 0);
    @(posedge Clock); #1;
    check({tag, "_valid_pulse"}, valid, 0);
    check({tag, "_result_held"}, result, er);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [4:0]  rop;
    int          n, pulses;

    #3;
    check("reset_result", result, 0);
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    @(negedge Clock); Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1 check("idle_result", result, 0);

    run_op("add_56_37", 16'd56, 16'd37, 5'd1);
    run_op("sub_49_37", 16'd49, 16'd37, 5'd2);
    run_op("sub_3_5", 16'd3, 16'd5, 5'd2);
    run_op("mul_300", 16'd300, 16'd300, 5'd3);
    run_op("mul_123_45", 16'd123, 16'd45, 5'd3);
    run_op("div_1000_7", 16'd1000, 16'd7, 5'd4);
    run_op("div_by0", 16'd9, 16'd0, 5'd4);
    run_op("add_carry", 16'hFFFF, 16'h0001, 5'd1);
    run_op("mul_max", 16'hFFFF, 16'hFFFF, 5'd3);
    run_op("div_max", 16'hFFFF, 16'h0001, 5'd4);
    run_op("op_zero", 16'd5, 16'd5, 5'd0);

    // finish during EXEC ignored; finish in the valid cycle accepted
    @(negedge Clock);
    DST = 16'd300; SRC = 16'd300; ALU_OP = 5'd3; finish = 1'b1;
    @(posedge Clock); #1;
    finish = 1'b0;
    repeat (4) @(posedge Clock);
    #1 DST = 16'd1; SRC = 16'd2; ALU_OP = 5'd1; finish = 1'b1;
    @(posedge Clock); #1;
    finish = 1'b0;
    check("ignore_busy", busy, 1);
    wait_valid(n);
    check("ignore_latency", n, 11);
    check("ignore_result", result, 24464);
    check("ignore_err", err, 1);
    DST = 16'd10; SRC = 16'd20; ALU_OP = 5'd1; finish = 1'b1;
    @(posedge Clock); #1;
    finish = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_valid_low", valid, 0);
    @(posedge Clock); #1;
    check("b2b_valid", valid, 1);
    check("b2b_result", result, 30);
    check("b2b_err", err, 0);

    // Asynchronous reset mid-division
    @(negedge Clock);
    DST = 16'd1000; SRC = 16'd7; ALU_OP = 5'd4; finish = 1'b1;
    @(posedge Clock); #1;
    finish = 1'b0;
    repeat (8) @(posedge Clock);
    #1 Reset = 1'b0;
    #1;
    check("abort_result", result, 0);
    check("abort_valid", valid, 0);
    check("abort_busy", busy, 0);
    check("abort_err", err, 0);
    @(negedge Clock); Reset = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(posedge Clock); #1;
      if (valid) pulses++;
    end
    check("abort_no_valid", pulses, 0);
    run_op("illegal_7", 16'd12, 16'd34, 5'd7);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 16'h0000;
        1: ra = 16'hFFFF;
        2: rb = 16'($urandom_range(1, 15));
        default: ;
      endcase
      rop = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(5, 31)) : 5'($urandom_range(1, 4));
      run_op($sformatf("rand%0d_op%0d", i, rop), ra, rb, rop);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
